uart_sender: RTL and testbench

UART_SENDER -- requirements
Module: uart_sender

---
 rtl/uart_sender.sv | 188 ++++++++++++++++++
 tb/tb_uart_sender.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_sender.sv
`default_nettype none
// ============================================================================
// Module   : uart_sender
// Purpose  : Byte-wide UART transmitter. A request (TX_EN) seen while idle
//            latches TX_DATA and emits one frame on UART_TX:
//            start bit (0), 8 data bits LSB first, optional even-parity bit,
//            stop bit (1). Every bit lasts BAUD_DIV sysclk cycles.
//
// Parameters:
//   BAUD_DIV   sysclk cycles per serial bit, legal range 2..65535
//              (default 5208 = 50 MHz / 9600 baud).
//
// Ports:
//   sysclk     in   1  system clock, all state changes on the rising edge
//   reset      in   1  synchronous, active-low reset
//   TX_DATA    in   8  byte to send, sampled only on the accept edge
//   TX_EN      in   1  level-sensitive transmit request
//   TX_STATUS  out  1  registered; 1 = idle/ready, 0 = frame in progress
//   UART_TX    out  1  registered serial line, idles at 1
//
// Build option:
//   UART_SENDER_PARITY_EN  when defined, an even-parity bit (XOR of the
//                          latched byte) is inserted between the last data
//                          bit and the stop bit, giving an 11-bit frame.
//                          Undefined (default): 10-bit frame, no parity
//                          logic at all.
//
// Revision : 1.0  initial release
// ============================================================================
module uart_sender #(
    parameter int BAUD_DIV = 5208
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] TX_DATA,
    input  logic       TX_EN,
    output logic       TX_STATUS,
    output logic       UART_TX
);

    // ------------------------------------------------------------------------
    // State encoding. Three bits leave spare codes; any of them falls back to
    // IDLE with the line and status forced to their idle values.
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_SENDER_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    // Terminal count of the baud counter: a bit spans counts 0..BAUD_DIV-1.
    localparam logic [15:0] c_BIT_LAST  = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  c_LAST_DATA = 3'd7;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [15:0] r_baud_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_status;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic        w_bit_done;
    logic [2:0]  w_next_idx;

    assign w_bit_done = (r_baud_cnt == c_BIT_LAST);
    assign w_next_idx = r_bit_idx + 3'd1;

`ifdef UART_SENDER_PARITY_EN
    logic        w_parity;
    // Even parity: the parity bit makes the total count of ones even.
    assign w_parity = ^r_shift;
`endif

    // ------------------------------------------------------------------------
    // Transmit sequencer. The latched byte is kept intact for the whole frame
    // (bits are selected by index rather than shifted out) so the parity bit
    // can be formed from it at the end of the data phase.
    //
    // The next line level is loaded into r_tx on the same edge that ends the
    // current bit, so the line only ever changes on bit boundaries.
    // ------------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_tx       <= 1'b1;
            r_status   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx       <= 1'b1;
                    r_status   <= 1'b1;
                    r_baud_cnt <= 16'd0;
                    r_bit_idx  <= 3'd0;
                    if (TX_EN) begin
                        // Accept: start bit goes out from the next cycle on.
                        r_shift  <= TX_DATA;
                        r_state  <= S_START;
                        r_tx     <= 1'b0;
                        r_status <= 1'b0;
                    end
                end

                S_START: begin
                    if (w_bit_done) begin
                        r_baud_cnt <= 16'd0;
                        r_bit_idx  <= 3'd0;
                        r_tx       <= r_shift[0];
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end

                S_DATA: begin
                    if (w_bit_done) begin
                        r_baud_cnt <= 16'd0;
                        if (r_bit_idx == c_LAST_DATA) begin
                            r_bit_idx <= 3'd0;
`ifdef UART_SENDER_PARITY_EN
                            r_tx      <= w_parity;
                            r_state   <= S_PARITY;
`else
                            r_tx      <= 1'b1;
                            r_state   <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_tx      <= r_shift[w_next_idx];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end

`ifdef UART_SENDER_PARITY_EN
                S_PARITY: begin
                    if (w_bit_done) begin
                        r_baud_cnt <= 16'd0;
                        r_tx       <= 1'b1;
                        r_state    <= S_STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end
`endif

                S_STOP: begin
                    if (w_bit_done) begin
                        // Ready is flagged on the edge that ends the stop
                        // bit; a held request is then taken one edge later,
                        // leaving exactly one idle cycle between frames.
                        r_baud_cnt <= 16'd0;
                        r_tx       <= 1'b1;
                        r_status   <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_baud_cnt <= 16'd0;
                    r_bit_idx  <= 3'd0;
                    r_tx       <= 1'b1;
                    r_status   <= 1'b1;
                end
            endcase
        end
    end

    // Outputs come straight from flip-flops.
    assign UART_TX   = r_tx;
    assign TX_STATUS = r_status;

endmodule
`default_nettype wire

// File: tb/tb_uart_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_sender
// Purpose  : Self-checking bench for uart_sender with BAUD_DIV = 4.
//            Expected line levels come from a frame model that lists the
//            frame's bits (start, data LSB first, optional parity, stop) and
//            stretches each over BAUD_DIV cycles.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_sender;

    localparam int BD = 4;
`ifdef UART_SENDER_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * BD;

    logic       sysclk;
    logic       reset;
    logic [7:0] TX_DATA;
    logic       TX_EN;
    logic       TX_STATUS;
    logic       UART_TX;

    int n_total;
    int n_bad;

    uart_sender #(.BAUD_DIV(BD)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .TX_DATA   (TX_DATA),
        .TX_EN     (TX_EN),
        .TX_STATUS (TX_STATUS),
        .UART_TX   (UART_TX)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference frame: list of bit levels in transmission order.
    function automatic void build_frame(input logic [7:0] d, output logic bits [0:10]);
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
`ifdef UART_SENDER_PARITY_EN
        bits[9]  = ^d;
        bits[10] = 1'b1;
`else
        bits[9]  = 1'b1;
        bits[10] = 1'b1;
`endif
    endfunction

    // Idle cycles with no request: line high, ready asserted.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            check_value("idle_status", 32'(TX_STATUS), 32'd1);
            check_value("idle_line", 32'(UART_TX), 32'd1);
            TX_EN   = 1'b0;
            TX_DATA = 8'($urandom);
            @(negedge sysclk);
        end
    endtask

    // Called on a negedge with the DUT idle. Requests byte d, then checks the
    // line and busy flag on every cycle of the frame. While busy, inputs are
    // either held (hold=1, TX_DATA=next_d), pulsed once at cycle pulse_at
    // with TX_DATA=0x00, or scrambled with TX_EN low.
    task automatic send_frame(input logic [7:0] d, input bit hold,
                              input logic [7:0] next_d, input int pulse_at);
        logic bits [0:10];
        build_frame(d, bits);
        check_value("ready", 32'(TX_STATUS), 32'd1);
        check_value("ready_line", 32'(UART_TX), 32'd1);
        TX_EN   = 1'b1;
        TX_DATA = d;
        @(negedge sysclk);
        for (int k = 0; k < FRAME_CYC; k++) begin
            check_value("line", 32'(UART_TX), 32'(bits[k / BD]));
            check_value("busy", 32'(TX_STATUS), 32'd0);
            if (hold) begin
                TX_EN   = 1'b1;
                TX_DATA = next_d;
            end else if (k == pulse_at) begin
                TX_EN   = 1'b1;
                TX_DATA = 8'h00;
            end else begin
                TX_EN   = 1'b0;
                TX_DATA = 8'($urandom);
            end
            @(negedge sysclk);
        end
        check_value("done_status", 32'(TX_STATUS), 32'd1);
        check_value("done_line", 32'(UART_TX), 32'd1);
        if (!hold) TX_EN = 1'b0;
    endtask

    initial begin
        logic [7:0] rb;
        logic       bits [0:10];
        n_total = 0;
        n_bad   = 0;

        // Reset with a request pending: request must be ignored.
        reset   = 1'b0;
        TX_EN   = 1'b1;
        TX_DATA = 8'hFF;
        repeat (3) @(negedge sysclk);
        check_value("reset_line", 32'(UART_TX), 32'd1);
        check_value("reset_status", 32'(TX_STATUS), 32'd1);

        // First accept on the first edge with reset released.
        reset = 1'b1;
        send_frame(8'h55, 1'b0, 8'h00, -1);
        idle_cycles(2);
        send_frame(8'hA3, 1'b0, 8'h00, -1);
        idle_cycles(2);

        // Held request across two frames, byte changes after first accept.
        send_frame(8'h0F, 1'b1, 8'hF0, -1);
        send_frame(8'hF0, 1'b0, 8'h00, -1);
        idle_cycles(3);

        // Request pulse during a frame is ignored; no second frame.
        send_frame(8'h81, 1'b0, 8'h00, 10);
        idle_cycles(6);

        // Reset during data bit 3 aborts the frame.
        build_frame(8'h99, bits);
        TX_EN   = 1'b1;
        TX_DATA = 8'h99;
        @(negedge sysclk);
        TX_EN = 1'b0;
        repeat (4 * BD + 1) @(negedge sysclk);
        check_value("pre_abort_line", 32'(UART_TX), 32'(bits[4]));
        check_value("pre_abort_busy", 32'(TX_STATUS), 32'd0);
        reset = 1'b0;
        TX_EN = 1'b1;
        @(negedge sysclk);
        check_value("abort_line", 32'(UART_TX), 32'd1);
        check_value("abort_status", 32'(TX_STATUS), 32'd1);
        reset = 1'b1;
        send_frame(8'h3C, 1'b0, 8'h00, -1);
        idle_cycles(2);

        // Randomized frames with random ignored pulses and idle gaps.
        for (int i = 0; i < 8; i++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b0, 8'h00,
                       ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, FRAME_CYC - 1)) : -1);
            idle_cycles(int'($urandom_range(1, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
